tz_rresp_buffer: RTL

//  - Read-response buffer directly upstream of the SoC peripheral read port.
//  - Feeds the downstream rdata / rdata_security_level inputs.
//  - Queues peripheral read responses, each tagged with its TrustZone security level.
//  - Scrubs secure data addressed to a non-secure requester before it is stored, so it

---
 rtl/tz_rresp_buffer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/tz_rresp_buffer.sv
// ---------------------------------------------------------------------------
// tz_rresp_buffer
//
// Read-response buffer that sits directly upstream of the SoC peripheral read
// port. It queues read responses, each tagged with its TrustZone security
// level, and feeds the downstream rdata / rdata_security_level inputs.
// Secure data that is returned to a non-secure requester is scrubbed to zero
// before it is written into storage, so it can never reach downstream logic.
// Each scrubbed push raises a one-cycle violation pulse.
//
// Parameters
//   DATA_W  width of read data
//   DEPTH   number of FIFO entries (power of two, >= 2)
//   CNT_W   width of the saturating violation counter
//
// Ports
//   clk                   single clock, all state changes on posedge
//   rst_n                 synchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready = !full)
//   in_data               response data
//   in_sec                1 = data is secure
//   in_master_ns          1 = requester of this response is non-secure
//   out_valid / out_ready downstream handshake (out_valid = !empty)
//   rdata                 head data, 0 while the buffer is empty
//   rdata_security_level  head security tag, 0 while the buffer is empty
//   violation             registered pulse, high the cycle after a scrubbed push
//   viol_count            saturating count of violation cycles
//
// Build option
//   TZ_VIOL_CNT_EN  when defined, viol_count counts violation cycles and
//                   saturates at all-ones; when undefined viol_count is tied
//                   to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module tz_rresp_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sec,
  input  logic              in_master_ns,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_security_level,
  output logic              violation,
  output logic [CNT_W-1:0]  viol_count
);

  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_W + 1;
  localparam logic [CNT_BITS-1:0] DEPTH_C = CNT_BITS'(DEPTH);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("tz_rresp_buffer: DEPTH must be a power of two and >= 2");
  end

  // Storage
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0]  sec_mem;

  // Queue state
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [CNT_BITS-1:0] count;
  logic                violation_q;

  // Handshake decode
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              scrub;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    full    = (count == DEPTH_C);
    empty   = (count == '0);
    // A full buffer never accepts, even when the head is popped this cycle.
    push    = in_valid & ~full;
    pop     = out_ready & ~empty;
    scrub   = in_sec & in_master_ns;
    wr_data = scrub ? '0 : in_data;
  end

  // Storage has no reset: contents are unobservable until written because
  // the outputs are gated by out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= wr_data;
      sec_mem[wr_ptr]  <= in_sec;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      violation_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      violation_q <= push & scrub;
    end
  end

  // Outputs: state-only, so there is no same-cycle path from in_* to out_*.
  always_comb begin
    in_ready             = ~full;
    out_valid            = ~empty;
    rdata                = empty ? '0 : data_mem[rd_ptr];
    rdata_security_level = empty ? 1'b0 : sec_mem[rd_ptr];
    violation            = violation_q;
  end

`ifdef TZ_VIOL_CNT_EN
  logic [CNT_W-1:0] viol_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      viol_cnt_q <= '0;
    end else if (violation_q && (viol_cnt_q != '1)) begin
      viol_cnt_q <= viol_cnt_q + 1'b1;
    end
  end

  assign viol_count = viol_cnt_q;
`else
  assign viol_count = '0;
`endif

  // Occupancy must stay within bounds and agree with the pointer distance.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (count <= DEPTH_C)
        else $error("tz_rresp_buffer: count overflow");
      assert (!(count == '0 && pop))
        else $error("tz_rresp_buffer: pop while empty");
      assert (!(full && push))
        else $error("tz_rresp_buffer: push while full");
      assert ((wr_ptr - rd_ptr) == count[PTR_W-1:0])
        else $error("tz_rresp_buffer: pointer/count mismatch");
    end
  end

endmodule
